// File: rtl/flash_bridge.sv
// Host-to-flash bridge. Turns host byte reads/writes into opcode/address and
// data handshakes with a flash master. Handles write enable, page wrap and timeout.
module flash_bridge #(
    parameter int FL_AW     = 24,
    parameter int N_CS      = 2,
    parameter int FAST_READ = 0,
    parameter int DUMMY     = 8,
    parameter int PAGE_BITS = 8,
    parameter int TO_W      = 16,
    localparam int CS_BITS  = (N_CS > 1) ? $clog2(N_CS) : 1,
    localparam int ADDR_W   = FL_AW + CS_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_addr_valid,
    input  logic              host_rd_prep,
    input  logic              host_wr_prep,
    input  logic [7:0]        host_wr_data,
    input  logic              host_wr_flag,
    input  logic              host_rd_flag,
    input  logic              host_op_active,
    output logic [7:0]        host_rd_data,
    output logic [7:0]        fl_opcode,
    output logic [FL_AW-1:0]  fl_addr,
    output logic              fl_addr_flag,
    output logic [3:0]        fl_dummy,
    output logic [7:0]        fl_wdata,
    output logic              fl_oa_trigger,
    output logic              fl_data_trigger,
    output logic              fl_finalize,
    output logic [N_CS-1:0]   fl_cs_sel,
    input  logic [7:0]        fl_rdata,
    input  logic              fl_oa_done,
    input  logic              fl_data_done,
    input  logic              fl_busy,
    input  logic              enable,
    input  logic              err_clr,
    output logic              err_busy,
    output logic              err_invalid,
    output logic              err_timeout,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WREN     = 4'd1,
        WREN_FIN = 4'd2,
        WAIT_RDY = 4'd3,
        OA       = 4'd4,
        RD       = 4'd5,
        WR       = 4'd6,
        FINAL    = 4'd14,
        ERR      = 4'd15
    } state_t;

    localparam logic [CS_BITS:0] N_CS_V  = (CS_BITS + 1)'(N_CS);
    localparam logic [3:0]       DUMMY_V = 4'(DUMMY);

    state_t             r_state, w_next;
    logic [FL_AW-1:0]   r_addr;
    logic               r_is_rd, r_buf_valid, r_hold_valid;
    logic [7:0]         r_hold_data;
    logic [TO_W-1:0]    r_to;
    logic               r_av_d, r_rf_d, r_wf_d, r_oad_d, r_dd_d;
    logic               r_err_busy, r_err_inv, r_err_to;

    logic               w_av_rise, w_rd_rise, w_wr_rise, w_oa_rise, w_dd_rise;
    logic [CS_BITS-1:0] w_cs_in;
    logic               w_cs_bad;
    logic [N_CS-1:0]    w_cs_onehot;
    logic [FL_AW-1:0]   w_addr_inc;
    logic               w_wrap, w_wr_send, w_wr_park, w_overflow;
    logic               w_set_busy, w_set_inv, w_set_to;

    assign w_av_rise  = host_addr_valid & ~r_av_d;
    assign w_rd_rise  = host_rd_flag & ~r_rf_d;
    assign w_wr_rise  = host_wr_flag & ~r_wf_d;
    assign w_oa_rise  = fl_oa_done & ~r_oad_d;
    assign w_dd_rise  = fl_data_done & ~r_dd_d;
    assign w_cs_in    = host_addr[ADDR_W-1 -: CS_BITS];
    assign w_cs_bad   = {1'b0, w_cs_in} >= N_CS_V;
    assign w_addr_inc = r_addr + FL_AW'(1);
    assign w_wrap     = (w_addr_inc[PAGE_BITS-1:0] == '0) && host_op_active;

    // Write bytes that cannot go out immediately are parked; a byte arriving
    // while the park slot is still occupied (and not draining) is an overrun.
    assign w_wr_send  = (r_state == WR) && !fl_data_trigger && (r_hold_valid || w_wr_rise);
    assign w_wr_park  = w_wr_rise && !r_is_rd &&
                        ((r_state inside {WREN, WREN_FIN, WAIT_RDY, OA}) ||
                         ((r_state == WR) && (fl_data_trigger || r_hold_valid)));
    assign w_overflow = w_wr_park && r_hold_valid && !w_wr_send;

    assign err_busy    = r_err_busy;
    assign err_invalid = r_err_inv;
    assign err_timeout = r_err_to;
    assign state       = r_state;

    always_comb begin
        w_cs_onehot = '0;
        for (int unsigned i = 0; i < N_CS; i++) begin
            w_cs_onehot[i] = (w_cs_in == CS_BITS'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_set_busy = 1'b0;
        w_set_inv  = 1'b0;
        w_set_to   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_av_rise && enable) begin
                    if (w_cs_bad || !(host_rd_prep || host_wr_prep)) begin
                        w_next    = ERR;
                        w_set_inv = 1'b1;
                    end else if (host_rd_prep) begin
                        w_next = OA;
                    end else begin
                        w_next = WREN;
                    end
                end
            end
            ERR:   w_next = FINAL;
            FINAL: w_next = IDLE;
            default: begin
                if (!host_op_active) begin
                    w_next = FINAL;
                end else if (r_to == '1) begin
                    w_next   = ERR;
                    w_set_to = 1'b1;
                end else if (w_overflow) begin
                    w_next     = ERR;
                    w_set_busy = 1'b1;
                end else begin
                    case (r_state)
                        WREN:     if (w_oa_rise) w_next = WREN_FIN;
                        WREN_FIN: w_next = WAIT_RDY;
                        WAIT_RDY: if (!fl_busy) w_next = OA;
                        OA:       if (w_oa_rise) w_next = r_is_rd ? RD : WR;
                        RD: begin
                            if (w_rd_rise && !r_buf_valid) begin
                                w_next     = ERR;
                                w_set_busy = 1'b1;
                            end
                        end
                        WR:       if (w_dd_rise && w_wrap) w_next = WREN;
                        default:  w_next = ERR;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {r_av_d, r_rf_d, r_wf_d, r_oad_d, r_dd_d} <= '0;
            r_addr          <= '0;
            r_is_rd         <= 1'b0;
            r_buf_valid     <= 1'b0;
            r_hold_valid    <= 1'b0;
            r_hold_data     <= '0;
            r_to            <= '0;
            r_err_busy      <= 1'b0;
            r_err_inv       <= 1'b0;
            r_err_to        <= 1'b0;
            host_rd_data    <= '0;
            fl_opcode       <= '0;
            fl_addr         <= '0;
            fl_addr_flag    <= 1'b0;
            fl_dummy        <= '0;
            fl_wdata        <= '1;
            fl_oa_trigger   <= 1'b0;
            fl_data_trigger <= 1'b0;
            fl_finalize     <= 1'b0;
            fl_cs_sel       <= N_CS'(1);
        end else begin
            {r_av_d, r_rf_d, r_wf_d, r_oad_d, r_dd_d} <=
                {host_addr_valid, host_rd_flag, host_wr_flag, fl_oa_done, fl_data_done};
            fl_finalize <= 1'b0;
            r_to        <= (w_next != r_state || r_state == IDLE) ? '0 : r_to + TO_W'(1);
            r_err_busy  <= w_set_busy | (r_err_busy & ~err_clr);
            r_err_inv   <= w_set_inv  | (r_err_inv  & ~err_clr);
            r_err_to    <= w_set_to   | (r_err_to   & ~err_clr);

            case (r_state)
                IDLE: begin
                    if (w_av_rise && enable && w_next != ERR) begin
                        r_addr    <= host_addr[FL_AW-1:0];
                        r_is_rd   <= host_rd_prep;
                        fl_cs_sel <= w_cs_onehot;
                    end
                end
                WREN: begin
                    // Hold off the trigger while a page-wrap finalize pulse is out.
                    if (w_oa_rise) begin
                        fl_oa_trigger <= 1'b0;
                    end else if (!fl_oa_trigger && !fl_finalize) begin
                        fl_oa_trigger <= 1'b1;
                        fl_opcode     <= 8'h06;
                        fl_addr_flag  <= 1'b0;
                    end
                end
                OA: begin
                    if (w_oa_rise) begin
                        fl_oa_trigger <= 1'b0;
                        if (r_is_rd) fl_data_trigger <= 1'b1;
                    end else if (!fl_oa_trigger) begin
                        fl_oa_trigger <= 1'b1;
                        fl_addr       <= r_addr;
                        fl_addr_flag  <= 1'b1;
                        if (!r_is_rd) begin
                            fl_opcode <= 8'h02;
                            fl_dummy  <= '0;
                        end else if (FAST_READ != 0) begin
                            fl_opcode <= 8'h0B;
                            fl_dummy  <= DUMMY_V;
                        end else begin
                            fl_opcode <= 8'h03;
                            fl_dummy  <= '0;
                        end
                    end
                end
                RD: begin
                    if (w_dd_rise) begin
                        fl_data_trigger <= 1'b0;
                        host_rd_data    <= fl_rdata;
                        r_buf_valid     <= 1'b1;
                        r_addr          <= w_addr_inc;
                    end
                    if (w_rd_rise && r_buf_valid) begin
                        r_buf_valid     <= 1'b0;
                        fl_data_trigger <= 1'b1;
                    end
                end
                WR: begin
                    if (w_dd_rise) begin
                        fl_data_trigger <= 1'b0;
                        r_addr          <= w_addr_inc;
                        if (w_wrap) fl_finalize <= 1'b1;
                    end
                    if (w_wr_send) begin
                        fl_wdata        <= r_hold_valid ? r_hold_data : host_wr_data;
                        fl_data_trigger <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_wr_send && r_hold_valid && !w_wr_park) r_hold_valid <= 1'b0;
            if (w_wr_park) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= host_wr_data;
            end

            if (w_next != r_state) begin
                if (w_next == WREN_FIN || w_next == FINAL) fl_finalize <= 1'b1;
                if (w_next == ERR || w_next == FINAL) begin
                    fl_oa_trigger   <= 1'b0;
                    fl_data_trigger <= 1'b0;
                    r_buf_valid     <= 1'b0;
                    r_hold_valid    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_bridge.sv
// Directed bench for flash_bridge: default instance for read/write/error paths,
// a second instance (fast read, 3 chip selects, short timeout) for the rest.
module tb_flash_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [24:0] host_addr;
    logic [25:0] host_addr_b;
    logic        host_addr_valid, host_rd_prep, host_wr_prep;
    logic [7:0]  host_wr_data;
    logic        host_wr_flag, host_rd_flag, host_op_active;
    logic [7:0]  fl_rdata;
    logic        fl_oa_done, fl_data_done, fl_busy;
    logic        enable_a, enable_b, err_clr;

    logic [7:0]  host_rd_data, fl_opcode, fl_wdata;
    logic [23:0] fl_addr;
    logic        fl_addr_flag, fl_oa_trigger, fl_data_trigger, fl_finalize;
    logic [3:0]  fl_dummy, state;
    logic [1:0]  fl_cs_sel;
    logic        err_busy, err_invalid, err_timeout;

    logic [7:0]  b_host_rd_data, b_fl_opcode, b_fl_wdata;
    logic [23:0] b_fl_addr;
    logic        b_fl_addr_flag, b_fl_oa_trigger, b_fl_data_trigger, b_fl_finalize;
    logic [3:0]  b_fl_dummy, b_state;
    logic [2:0]  b_fl_cs_sel;
    logic        b_err_busy, b_err_invalid, b_err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int fin_a = 0;
    int fin_b = 0;
    int f0, k;

    flash_bridge #(.FL_AW(24), .N_CS(2), .FAST_READ(0), .DUMMY(8), .PAGE_BITS(8), .TO_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr), .host_addr_valid(host_addr_valid),
        .host_rd_prep(host_rd_prep), .host_wr_prep(host_wr_prep),
        .host_wr_data(host_wr_data), .host_wr_flag(host_wr_flag),
        .host_rd_flag(host_rd_flag), .host_op_active(host_op_active),
        .host_rd_data(host_rd_data),
        .fl_opcode(fl_opcode), .fl_addr(fl_addr), .fl_addr_flag(fl_addr_flag),
        .fl_dummy(fl_dummy), .fl_wdata(fl_wdata), .fl_oa_trigger(fl_oa_trigger),
        .fl_data_trigger(fl_data_trigger), .fl_finalize(fl_finalize), .fl_cs_sel(fl_cs_sel),
        .fl_rdata(fl_rdata), .fl_oa_done(fl_oa_done), .fl_data_done(fl_data_done), .fl_busy(fl_busy),
        .enable(enable_a), .err_clr(err_clr),
        .err_busy(err_busy), .err_invalid(err_invalid), .err_timeout(err_timeout), .state(state)
    );

    flash_bridge #(.FL_AW(24), .N_CS(3), .FAST_READ(1), .DUMMY(8), .PAGE_BITS(8), .TO_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr_b), .host_addr_valid(host_addr_valid),
        .host_rd_prep(host_rd_prep), .host_wr_prep(host_wr_prep),
        .host_wr_data(host_wr_data), .host_wr_flag(host_wr_flag),
        .host_rd_flag(host_rd_flag), .host_op_active(host_op_active),
        .host_rd_data(b_host_rd_data),
        .fl_opcode(b_fl_opcode), .fl_addr(b_fl_addr), .fl_addr_flag(b_fl_addr_flag),
        .fl_dummy(b_fl_dummy), .fl_wdata(b_fl_wdata), .fl_oa_trigger(b_fl_oa_trigger),
        .fl_data_trigger(b_fl_data_trigger), .fl_finalize(b_fl_finalize), .fl_cs_sel(b_fl_cs_sel),
        .fl_rdata(fl_rdata), .fl_oa_done(fl_oa_done), .fl_data_done(fl_data_done), .fl_busy(fl_busy),
        .enable(enable_b), .err_clr(err_clr),
        .err_busy(b_err_busy), .err_invalid(b_err_invalid), .err_timeout(b_err_timeout), .state(b_state)
    );

    always @(negedge clk) begin
        if (fl_finalize)   fin_a++;
        if (b_fl_finalize) fin_b++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic trig(input bit bdut, input bit dat);
        if (bdut) return dat ? b_fl_data_trigger : b_fl_oa_trigger;
        return dat ? fl_data_trigger : fl_oa_trigger;
    endfunction

    task automatic wait_trig(input bit bdut, input bit dat, input string tag);
        int n = 0;
        while (trig(bdut, dat) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(trig(bdut, dat)), 1);
    endtask

    task automatic start(input logic [25:0] addr, input bit rd, input bit wr);
        host_addr       = addr[24:0];
        host_addr_b     = addr;
        host_rd_prep    = rd;
        host_wr_prep    = wr;
        host_op_active  = 1'b1;
        host_addr_valid = 1'b1;
        tick();
        host_addr_valid = 1'b0;
        host_rd_prep    = 1'b0;
        host_wr_prep    = 1'b0;
    endtask

    task automatic pulse_oa();
        fl_oa_done = 1'b1;
        tick();
        fl_oa_done = 1'b0;
    endtask

    task automatic pulse_dd();
        fl_data_done = 1'b1;
        tick();
        fl_data_done = 1'b0;
    endtask

    task automatic host_read();
        host_rd_flag = 1'b1;
        tick();
        host_rd_flag = 1'b0;
        tick();
    endtask

    task automatic host_write(input logic [7:0] d);
        host_wr_data = d;
        host_wr_flag = 1'b1;
        tick();
        host_wr_flag = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        host_addr = '0; host_addr_b = '0;
        host_addr_valid = 0; host_rd_prep = 0; host_wr_prep = 0;
        host_wr_data = '0; host_wr_flag = 0; host_rd_flag = 0; host_op_active = 0;
        fl_rdata = '0; fl_oa_done = 0; fl_data_done = 0; fl_busy = 0;
        enable_a = 0; enable_b = 0; err_clr = 0;
        tick(2);

        check("rst_state", state, 0);
        check("rst_opcode", fl_opcode, 8'h00);
        check("rst_addr", fl_addr, 0);
        check("rst_aflag", fl_addr_flag, 0);
        check("rst_dummy", fl_dummy, 0);
        check("rst_wdata", fl_wdata, 8'hFF);
        check("rst_rdata", host_rd_data, 8'h00);
        check("rst_cs", fl_cs_sel, 2'b01);
        check("rst_trig", {fl_oa_trigger, fl_data_trigger, fl_finalize}, 0);
        check("rst_errs", {err_busy, err_invalid, err_timeout}, 0);
        check("rst_b_state", b_state, 0);
        check("rst_b_out", {b_fl_opcode, b_fl_wdata, b_host_rd_data}, 24'h00FF00);
        check("rst_b_addr", {b_fl_addr, b_fl_dummy, b_fl_addr_flag}, 0);
        check("rst_b_cs", b_fl_cs_sel, 3'b001);
        check("rst_b_errs", {b_err_busy, b_err_invalid, b_err_timeout}, 0);
        rst_n = 1'b1;
        tick(2);

        // enable low: start ignored
        start(26'h0000100, 1, 0);
        tick(2);
        check("dis_state", state, 0);
        check("dis_trig", fl_oa_trigger, 0);
        host_op_active = 0;
        enable_a = 1;
        tick();

        // read 3 bytes from CS0 0x000100
        f0 = fin_a;
        start(26'h0000100, 1, 0);
        wait_trig(0, 0, "rd_oa_trig");
        check("rd_opcode", fl_opcode, 8'h03);
        check("rd_addr", fl_addr, 24'h000100);
        check("rd_aflag", fl_addr_flag, 1);
        check("rd_dummy", fl_dummy, 0);
        check("rd_cs", fl_cs_sel, 2'b01);
        pulse_oa();
        for (int i = 0; i < 3; i++) begin
            wait_trig(0, 1, $sformatf("rd_pref%0d", i));
            fl_rdata = 8'(8'hA1 + i);
            pulse_dd();
            host_read();
            check($sformatf("rd_byte%0d", i), host_rd_data, 8'hA1 + i);
        end
        host_op_active = 0;
        tick(3);
        check("rd_fin_cnt", fin_a - f0, 1);
        check("rd_end_state", state, 0);
        check("rd_end_trig", fl_data_trigger, 0);

        // write 4 bytes at 0x0000FE across a page boundary
        f0 = fin_a;
        start(26'h00000FE, 0, 1);
        wait_trig(0, 0, "wr_wren_trig");
        check("wr_wren_op", fl_opcode, 8'h06);
        check("wr_wren_aflag", fl_addr_flag, 0);
        pulse_oa();
        check("wr_wrenfin", {state, 3'b0, fl_finalize}, {4'd2, 4'd1});
        wait_trig(0, 0, "wr_oa_trig");
        check("wr_op", fl_opcode, 8'h02);
        check("wr_addr", fl_addr, 24'h0000FE);
        check("wr_aflag", fl_addr_flag, 1);
        pulse_oa();
        host_write(8'h11);
        check("wr_b0", {fl_wdata, 7'b0, fl_data_trigger}, {8'h11, 8'h01});
        pulse_dd();
        host_write(8'h22);
        check("wr_b1", fl_wdata, 8'h22);
        pulse_dd();
        check("wrap_state", state, 1);
        check("wrap_fin", fl_finalize, 1);
        host_write(8'h33);
        check("wrap_parked", fl_data_trigger, 0);
        wait_trig(0, 0, "re_wren_trig");
        check("re_wren_op", fl_opcode, 8'h06);
        pulse_oa();
        wait_trig(0, 0, "re_oa_trig");
        check("re_op", fl_opcode, 8'h02);
        check("re_addr", fl_addr, 24'h000100);
        pulse_oa();
        tick();
        check("wr_b2_held", {fl_wdata, 7'b0, fl_data_trigger}, {8'h33, 8'h01});
        pulse_dd();
        host_write(8'h44);
        check("wr_b3", fl_wdata, 8'h44);
        pulse_dd();
        host_op_active = 0;
        tick(3);
        check("wr_fin_cnt", fin_a - f0, 4);
        check("wr_end_state", state, 0);

        // chip select 1
        start(26'h1000010, 1, 0);
        wait_trig(0, 0, "cs1_trig");
        check("cs1_sel", fl_cs_sel, 2'b10);
        check("cs1_addr", fl_addr, 24'h000010);
        host_op_active = 0;
        tick(3);
        check("cs1_abort_trig", fl_oa_trigger, 0);
        check("cs1_abort_state", state, 0);

        // host read overruns prefetch
        f0 = fin_a;
        start(26'h0000000, 1, 0);
        wait_trig(0, 0, "busy_oa_trig");
        pulse_oa();
        wait_trig(0, 1, "busy_pref");
        fl_rdata = 8'hA5;
        pulse_dd();
        host_read();
        check("busy_byte", host_rd_data, 8'hA5);
        host_read();
        tick(2);
        check("busy_flag", err_busy, 1);
        check("busy_fin_cnt", fin_a - f0, 1);
        check("busy_state", state, 0);
        tick(5);
        check("busy_sticky", err_busy, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("busy_clr", err_busy, 0);
        host_op_active = 0;
        tick();

        // neither prep: invalid, raised while err_clr is held (set wins)
        err_clr = 1;
        start(26'h0000000, 0, 0);
        err_clr = 0;
        check("inv_set_wins", err_invalid, 1);
        tick(3);
        check("inv_state", state, 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("inv_clr", err_invalid, 0);
        host_op_active = 0;
        enable_a = 0;
        enable_b = 1;
        tick();

        // fast read opcode, then timeout with no oa_done
        f0 = fin_b;
        start(26'h0000200, 1, 0);
        tick();
        check("fr_trig", b_fl_oa_trigger, 1);
        check("fr_opcode", b_fl_opcode, 8'h0B);
        check("fr_dummy", b_fl_dummy, 4'd8);
        k = 1;
        while (!b_err_timeout && k < 40) begin
            tick();
            k++;
        end
        check("to_cycles", 32'(k >= 15 && k <= 17), 1);
        tick(3);
        check("to_fin_cnt", fin_b - f0, 1);
        check("to_state", b_state, 0);
        check("to_sticky", b_err_timeout, 1);
        check("a_ignored", state, 0);

        // chip select index 3 of 3
        start(26'h3000010, 1, 0);
        check("cs3_invalid", b_err_invalid, 1);
        tick(3);
        check("cs3_state", b_state, 0);
        enable_b = 0;
        host_op_active = 0;
        tick();

        // reset mid-transaction aborts without finalize
        enable_a = 1;
        f0 = fin_a;
        start(26'h00000FE, 0, 1);
        wait_trig(0, 0, "rstab_trig");
        rst_n = 1'b0;
        #1;
        check("rstab_state", state, 0);
        check("rstab_trig_off", {fl_oa_trigger, fl_finalize}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("rstab_fin_cnt", fin_a - f0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
